// File: rtl/ucode_fetch_if.sv
// ucode_fetch_if: SRAM read port and decoder valid/ready handshake of the microcode fetch stage.
interface ucode_fetch_if #(
    parameter int ADDR_W = 10
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [127:0]      mem_rd_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [127:0]      instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_rd_en, mem_rd_addr, instr_valid, instr_data, instr_pc,
        input  mem_rd_data, instr_ready
    );
    modport slave (
        input  mem_rd_en, mem_rd_addr, instr_valid, instr_data, instr_pc,
        output mem_rd_data, instr_ready
    );
endinterface

// File: rtl/ucode_fetch.sv
// ucode_fetch: microcode fetch/prefetch stage, SRAM words into a small FIFO presented over valid/ready.
// Define UCODE_FETCH_OPCODE_CHECK_EN to enable the opcode legality check and the err_illegal port.
module ucode_fetch #(
    parameter int UCODE_ADDR_W = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [UCODE_ADDR_W-1:0] start_pc,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic                    err_pc_wrap,
`ifdef UCODE_FETCH_OPCODE_CHECK_EN
    output logic                    err_illegal,
`endif
    ucode_fetch_if.master           bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t                  state, state_n;
    logic [UCODE_ADDR_W-1:0] pc;
    logic                    inflight;
    logic [CW-1:0]           count;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [127:0]            fifo_data [FIFO_DEPTH];
    logic [UCODE_ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic                    issue, ret, is_end, illegal, push, pop, stop, go;

    assign is_end = bus.mem_rd_data[7:0] == 8'hFF;
`ifdef UCODE_FETCH_OPCODE_CHECK_EN
    assign illegal = bus.mem_rd_data[7:0] > 8'd13 && !is_end;
`else
    assign illegal = 1'b0;
`endif
    // returns arriving outside FETCH are speculative reads past END and are dropped
    assign ret   = inflight && state == FETCH && !flush;
    assign push  = ret && !illegal;
    assign stop  = ret && (is_end || illegal);
    assign pop   = bus.instr_valid && bus.instr_ready;
    assign go    = state == IDLE && start && !flush;
    assign issue = state == FETCH && !flush && !err_pc_wrap && int'(count) + int'(inflight) < FIFO_DEPTH;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb
        state_n = flush          ? IDLE :
                  state == IDLE  ? (start ? FETCH : IDLE) :
                  state == FETCH ? ((stop || (err_pc_wrap && !inflight)) ? DRAIN : FETCH) :
                  (done || count == '0) ? IDLE : DRAIN;

    always_comb begin
        busy            = state != IDLE;
        bus.mem_rd_en   = issue;
        bus.mem_rd_addr = pc;
        bus.instr_valid = count != '0 && !flush;
        bus.instr_data  = bus.instr_valid ? fifo_data[rd_ptr] : '0;
        bus.instr_pc    = bus.instr_valid ? fifo_pc[rd_ptr] : '0;
        done            = bus.instr_valid && bus.instr_ready && bus.instr_data[7:0] == 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_pc_wrap <= 1'b0;
        end else begin
            inflight <= issue;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (go) begin
                pc          <= start_pc;
                err_pc_wrap <= 1'b0;
            end else if (issue) begin
                pc <= pc + 1'b1;
                if (&pc) err_pc_wrap <= 1'b1;
            end
        end
    end

`ifdef UCODE_FETCH_OPCODE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)              err_illegal <= 1'b0;
        else if (go)             err_illegal <= 1'b0;
        else if (ret && illegal) err_illegal <= 1'b1;
`endif

    // pc has advanced exactly once since the returning word was issued
    always_ff @(posedge clk)
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rd_data;
            fifo_pc[wr_ptr]   <= pc - 1'b1;
        end
endmodule
